// File: rtl/core_sel_sched.sv
// Run-time VGA source scheduler: switches among N_CORES demo cores at frame boundaries.
// Optional macro AUTO_CYCLE_EN advances to the next core every AUTO_FRAMES frames in RUN.
module core_sel_sched #(
  parameter int N_CORES      = 4,
  parameter int DEB_CYCLES   = 250000,
  parameter int RST_CYCLES   = 16,
  parameter int BLANK_FRAMES = 2,
  parameter int AUTO_FRAMES  = 600
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             keys,
  input  logic [N_CORES-1:0]     core_hsync,
  input  logic [N_CORES-1:0]     core_vsync,
  input  logic [3*N_CORES-1:0]   core_rgb,
  output logic [N_CORES-1:0]     core_reset,
  output logic                   hsync,
  output logic                   vsync,
  output logic [2:0]             rgb,
  output logic [1:0]             sel,
  output logic                   busy
);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT_VS = 2'd1, RST_HOLD = 2'd2, BLANK = 2'd3} state_t;

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int FRM_W = $clog2(BLANK_FRAMES + 1);
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(BLANK_FRAMES - 1);
  localparam logic [1:0]         SEL_LAST = 2'(N_CORES - 1);
  localparam logic [N_CORES-1:0] ALL_ONES = {N_CORES{1'b1}};
  localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

  logic [2:0]       sync1_r, sync2_r, deb_lvl_r, deb_lvl_d_r, press_s;
  logic [DEB_W-1:0] deb_cnt_r [3];
  state_t           state_r, state_nx_s;
  logic [1:0]       sel_r, sel_nx_s, target_r, target_nx_s;
  logic [N_CORES-1:0] core_reset_r, core_reset_nx_s;
  logic [RST_W-1:0] rst_cnt_r, rst_cnt_nx_s;
  logic [FRM_W-1:0] frm_cnt_r, frm_cnt_nx_s;
  logic             vs_d_r, vs_rise_s, auto_tc_s;
  logic             hsync_r, vsync_r, busy_r;
  logic [2:0]       rgb_r, rgb_sel_s;
  logic             unused_key_s;

  assign unused_key_s = keys[3];

  // Key synchronizers and per-key debounce counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r     <= 3'b000;
      sync2_r     <= 3'b000;
      deb_lvl_r   <= 3'b000;
      deb_lvl_d_r <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= {DEB_W{1'b0}};
    end else begin
      sync1_r     <= keys[2:0];
      sync2_r     <= sync1_r;
      deb_lvl_d_r <= deb_lvl_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == deb_lvl_r[i]) begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
          deb_lvl_r[i] <= sync2_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
        end
      end
    end
  end

  assign press_s   = deb_lvl_r & ~deb_lvl_d_r;
  assign vs_rise_s = core_vsync[sel_r] & ~vs_d_r;
  assign rgb_sel_s = core_rgb[3*int'(sel_r) +: 3];

`ifdef AUTO_CYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
  logic [AUTO_W-1:0] auto_cnt_r;

  assign auto_tc_s = (state_r == RUN) && vs_rise_s && (auto_cnt_r == AUTO_LAST);

  // Frame counter for automatic advance; cleared by presses and whenever RUN is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if ((state_nx_s != RUN) || (|press_s)) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if (vs_rise_s) begin
      auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
    end else begin
      auto_cnt_r <= auto_cnt_r;
    end
  end
`else
  logic unused_auto_s;
  assign unused_auto_s = (AUTO_FRAMES > 0);
  assign auto_tc_s     = 1'b0;
`endif

  // Next-state and datapath decisions; restart outranks next, next outranks prev
  always_comb begin
    state_nx_s      = state_r;
    sel_nx_s        = sel_r;
    target_nx_s     = target_r;
    core_reset_nx_s = core_reset_r;
    rst_cnt_nx_s    = rst_cnt_r;
    frm_cnt_nx_s    = frm_cnt_r;
    case (state_r)
      RUN: begin
        if (press_s[2]) begin
          target_nx_s = sel_r;
          state_nx_s  = WAIT_VS;
        end else if (press_s[0] || auto_tc_s) begin
          target_nx_s = (sel_r == SEL_LAST) ? 2'd0 : sel_r + 2'd1;
          state_nx_s  = WAIT_VS;
        end else if (press_s[1]) begin
          target_nx_s = (sel_r == 2'd0) ? SEL_LAST : sel_r - 2'd1;
          state_nx_s  = WAIT_VS;
        end else begin
          state_nx_s = RUN;
        end
      end
      WAIT_VS: begin
        if (vs_rise_s) begin
          sel_nx_s        = target_r;
          core_reset_nx_s = ALL_ONES;
          rst_cnt_nx_s    = {RST_W{1'b0}};
          state_nx_s      = RST_HOLD;
        end else begin
          state_nx_s = WAIT_VS;
        end
      end
      RST_HOLD: begin
        if (rst_cnt_r == RST_LAST) begin
          core_reset_nx_s = ALL_ONES & ~(ONE_HOT0 << sel_r);
          frm_cnt_nx_s    = {FRM_W{1'b0}};
          state_nx_s      = BLANK;
        end else begin
          rst_cnt_nx_s = rst_cnt_r + RST_W'(1);
        end
      end
      BLANK: begin
        if (vs_rise_s && (frm_cnt_r == FRM_LAST)) begin
          state_nx_s = RUN;
        end else if (vs_rise_s) begin
          frm_cnt_nx_s = frm_cnt_r + FRM_W'(1);
        end else begin
          state_nx_s = BLANK;
        end
      end
      default: begin
        state_nx_s      = RST_HOLD;
        sel_nx_s        = 2'd0;
        target_nx_s     = 2'd0;
        core_reset_nx_s = ALL_ONES;
        rst_cnt_nx_s    = {RST_W{1'b0}};
        frm_cnt_nx_s    = {FRM_W{1'b0}};
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= RST_HOLD;
      sel_r        <= 2'd0;
      target_r     <= 2'd0;
      core_reset_r <= ALL_ONES;
      rst_cnt_r    <= {RST_W{1'b0}};
      frm_cnt_r    <= {FRM_W{1'b0}};
      vs_d_r       <= 1'b0;
      hsync_r      <= 1'b0;
      vsync_r      <= 1'b0;
      rgb_r        <= 3'b000;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_nx_s;
      sel_r        <= sel_nx_s;
      target_r     <= target_nx_s;
      core_reset_r <= core_reset_nx_s;
      rst_cnt_r    <= rst_cnt_nx_s;
      frm_cnt_r    <= frm_cnt_nx_s;
      vs_d_r       <= core_vsync[sel_r];
      hsync_r      <= core_hsync[sel_r];
      vsync_r      <= core_vsync[sel_r];
      rgb_r        <= (state_r == RUN) ? rgb_sel_s : 3'b000;
      busy_r       <= (state_nx_s != RUN);
    end
  end

  assign core_reset = core_reset_r;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign rgb        = rgb_r;
  assign sel        = sel_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_core_sel_sched.sv
// Directed self-checking bench for core_sel_sched: key switching, wrap, debounce,
// restart, dropped presses, async reset and (optionally) automatic cycling.
module tb_core_sel_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  keys = 4'b0000;
  logic [3:0]  core_hsync, core_vsync, core_reset;
  logic [11:0] core_rgb;
  logic        hsync, vsync, busy;
  logic [2:0]  rgb;
  logic [1:0]  sel;
  int          cyc = 0;
  int          tests_run = 0;
  int          fails = 0;

  core_sel_sched #(
    .N_CORES(4), .DEB_CYCLES(4), .RST_CYCLES(8), .BLANK_FRAMES(2), .AUTO_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys),
    .core_hsync(core_hsync), .core_vsync(core_vsync), .core_rgb(core_rgb),
    .core_reset(core_reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rgb_f(input int c, input int i);
    return 3'(c + i);
  endfunction

  function automatic logic hs_f(input int c, input int i);
    return ((c + i) % 8) < 2;
  endfunction

  function automatic logic vs_f(input int c);
    return (c % 100) < 10;
  endfunction

  task automatic drive_cores();
    for (int i = 0; i < 4; i++) begin
      core_hsync[i]        = hs_f(cyc, i);
      core_vsync[i]        = vs_f(cyc);
      core_rgb[3*i +: 3]   = rgb_f(cyc, i);
    end
  endtask

  // Core models change just after each rising edge
  initial begin
    drive_cores();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      drive_cores();
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_wait"}, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_creset(input logic [3:0] exp, input int budget, input string tag);
    int n = 0;
    while (core_reset !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_creset_wait"}, 32'(core_reset), 32'(exp));
  endtask

  task automatic do_switch(input logic [3:0] k, input logic [1:0] exp_sel, input string tag);
    keys = k;
    repeat (10) @(negedge clk);
    keys = 4'b0000;
    check({tag, "_busy_after_press"}, 32'(busy), 32'd1);
    wait_creset(4'hF, 300, tag);
    check({tag, "_sel_switch"}, 32'(sel), 32'(exp_sel));
    repeat (7) @(negedge clk);
    check({tag, "_hold_8"}, 32'(core_reset), 32'hF);
    @(negedge clk);
    check({tag, "_release"}, 32'(core_reset), 32'(4'(~(4'b0001 << exp_sel))));
    check({tag, "_blank_rgb"}, 32'(rgb), 32'd0);
    wait_busy(1'b0, 400, tag);
    @(negedge clk);
    check({tag, "_rgb_follow"}, 32'(rgb), 32'(rgb_f(cyc - 1, int'(exp_sel))));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_creset", 32'(core_reset), 32'hF);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);

    // Startup: 8 cycles of reset, then blank until second vsync rise
    reset = 1'b0;
    repeat (7) @(negedge clk);
    check("start_hold_8", 32'(core_reset), 32'hF);
    @(negedge clk);
    check("start_release", 32'(core_reset), 32'hE);
    check("start_blank_rgb", 32'(rgb), 32'd0);
    check("start_blank_busy", 32'(busy), 32'd1);
    wait_busy(1'b0, 400, "start");
    @(negedge clk);
    check("start_rgb", 32'(rgb), 32'(rgb_f(cyc - 1, 0)));
    check("start_hsync", 32'(hsync), 32'(hs_f(cyc - 1, 0)));
    check("start_vsync", 32'(vsync), 32'(vs_f(cyc - 1)));
    check("start_sel", 32'(sel), 32'd0);

    // Next, prev and wrap-around both ways
    do_switch(4'b0001, 2'd1, "next_0_1");
    do_switch(4'b0010, 2'd0, "prev_1_0");
    do_switch(4'b0010, 2'd3, "prev_wrap");
    do_switch(4'b0001, 2'd0, "next_wrap");

    // Short glitch must not register as a press
    keys = 4'b0001;
    repeat (3) @(negedge clk);
    keys = 4'b0000;
    repeat (20) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_sel", 32'(sel), 32'd0);

    // Restart wins over next when pressed together
    do_switch(4'b0001, 2'd1, "next_0_1b");
    do_switch(4'b0001, 2'd2, "next_1_2");
    do_switch(4'b0101, 2'd2, "restart");

    // Prev during BLANK is dropped
    keys = 4'b0001;
    repeat (10) @(negedge clk);
    keys = 4'b0000;
    wait_creset(4'b0111, 400, "to_blank");
    keys = 4'b0010;
    repeat (10) @(negedge clk);
    keys = 4'b0000;
    check("blank_press_busy", 32'(busy), 32'd1);
    wait_busy(1'b0, 400, "blank_press");
    check("blank_press_sel", 32'(sel), 32'd3);
    repeat (30) @(negedge clk);
    check("blank_press_dropped_busy", 32'(busy), 32'd0);
    check("blank_press_dropped_sel", 32'(sel), 32'd3);

    // Asynchronous reset while in RST_HOLD
    keys = 4'b0010;
    repeat (10) @(negedge clk);
    keys = 4'b0000;
    wait_creset(4'hF, 300, "to_rst_hold");
    check("rst_hold_sel", 32'(sel), 32'd2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_creset", 32'(core_reset), 32'hF);
    check("async_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_busy(1'b0, 400, "after_async_rst");
    check("after_async_rst_sel", 32'(sel), 32'd0);

`ifdef AUTO_CYCLE_EN
    // Automatic advance after 3 frames in RUN
    wait_busy(1'b1, 350, "auto_leave_run");
    wait_busy(1'b0, 400, "auto_back_run");
    check("auto_sel", 32'(sel), 32'd1);
`else
    // No automatic switching without the feature
    for (int f = 0; f < 10; f++) begin
      repeat (100) @(negedge clk);
      check("no_auto_sel", 32'(sel), 32'd0);
      check("no_auto_busy", 32'(busy), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
